wb_master_bridge: RTL and testbench
===================================

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles spent in BUS waiting for termination; 0 disables the timeout.
REQ-002 clk_i  input  1  single clock; all logic is on the rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 req_i  input  1  core request strobe.
REQ-005 we_i  input  1  core write enable: 1 = write, 0 = read.
REQ-006 addr_i  input  32  core byte address.
REQ-007 data_i  input  32  core write data.
REQ-008 sel_i  input  4  core byte enables.
REQ-009 gnt_o  output  1  request accepted this cycle.
REQ-010 valid_o  output  1  single-cycle response pulse.
REQ-011 data_o  output  32  read data.
REQ-012 err_o  output  1  response is an error (bus error or timeout).
REQ-013 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone master cycle, strobe and write-enable signals.
REQ-014 wb_adr_o  output  32;  wb_dat_o  output  32;  wb_sel_o  output  4  Wishbone master address, write data and byte selects.
REQ-015 wb_dat_i  input  32;  wb_ack_i  input  1;  wb_err_i  input  1  Wishbone slave read data and terminations.

Function
REQ-016 Controller SHALL have three states: IDLE, BUS, RESP; reset state is IDLE.
REQ-017 gnt_o SHALL equal (state == IDLE) and (not rst_i), combinationally.
REQ-018 In IDLE with req_i = 1:
  - capture we_i, addr_i, data_i, sel_i into registers in the same cycle;
  - move to BUS on the next edge.
REQ-019 In IDLE with req_i = 0, the block SHALL remain in IDLE and hold all bus outputs low.
REQ-020 In BUS:
  - wb_cyc_o = wb_stb_o = 1;
  - wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o are driven from the captured registers;
  - these outputs stay stable until termination.
REQ-021 Outside BUS, wb_cyc_o, wb_stb_o and wb_we_o SHALL be 0; wb_adr_o, wb_dat_o and wb_sel_o SHALL hold their last captured values.
REQ-022 BUS with wb_ack_i = 1 and wb_err_i = 0: capture wb_dat_i if a read (0 if a write), clear the error flag, go to RESP.
REQ-023 BUS with wb_err_i = 1: set the error flag and set response data to 0, go to RESP; err wins when ack and err are asserted in the same cycle.
REQ-024 Timeout counter:
  - cleared on entry to BUS;
  - increments each BUS cycle without termination.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no ack/err, the block SHALL terminate as in REQ-023.
  - Counter width is clog2(TIMEOUT+1), minimum 1.
REQ-025 wb_cyc_o and wb_stb_o SHALL deassert on the edge following termination; the block never holds cyc for more than one cycle after a termination.
REQ-026 In RESP, valid_o = 1 for exactly one cycle, with data_o and err_o driven from the response registers; next state is IDLE.
REQ-027 Outside RESP, valid_o SHALL be 0; data_o and err_o hold their values until the next RESP.
REQ-028 Latency: request accepted in cycle N; stb first high in N+1; ack in cycle M (M >= N+1); valid_o high in M+1.
REQ-029 Minimum spacing is 3 cycles per transaction; gnt_o is never asserted in BUS or RESP, and req_i in those states SHALL be ignored.
REQ-030 wb_ack_i, wb_err_i and wb_dat_i outside BUS SHALL be ignored and SHALL NOT change any state or output.
REQ-031 At most one transaction SHALL be outstanding; there is no pipelining and no burst or block cycles.

Reset
REQ-032 While rst_i = 1 at an edge, the following SHALL all be 0: state register (IDLE), captured registers, response registers, timeout counter, and every output.
REQ-033 Reset asserted in BUS or RESP SHALL abort the transaction: cyc/stb low on the next edge, and no valid_o pulse for the aborted access.
REQ-034 gnt_o SHALL be 0 during every cycle rst_i = 1.

Verification
REQ-035 Read: req_i=1, we_i=0, addr_i=0x100, sel_i=0xF in cycle 0; slave acks in cycle 2 with wb_dat_i=0xDEADBEEF -> valid_o=1 in cycle 3, data_o=0xDEADBEEF, err_o=0, wb_adr_o=0x100 in cycles 1-2.
REQ-036 Write: req_i=1, we_i=1, addr_i=0x4, data_i=0x12345678, sel_i=0x3; ack in cycle 1 -> wb_we_o=1, wb_dat_o=0x12345678, wb_sel_o=0x3 in cycle 1; valid_o=1 in cycle 2 with data_o=0, err_o=0.
REQ-037 Error priority: wb_ack_i=1 and wb_err_i=1 in the same BUS cycle -> valid_o=1 next cycle with err_o=1, data_o=0.
REQ-038 Timeout: TIMEOUT=16, slave never responds -> cyc high for exactly 16 cycles, then valid_o=1 with err_o=1.
REQ-039 Back-to-back: req_i held high for two reads -> gnt_o high in cycles 0 and 3 only with ack every first BUS cycle; stray wb_ack_i in IDLE causes no valid_o.
REQ-040 Reset mid-BUS: rst_i=1 in cycle 2 of a read -> wb_cyc_o=0 from cycle 3, valid_o never pulses, gnt_o=1 in the first cycle after rst_i drops.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic master: captures one core request,
// runs it on the bus with an optional timeout, and returns a one-cycle response.
module wb_master_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic        gnt_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, next_state;

    logic          cap_we;
    logic [31:0]   cap_adr;
    logic [31:0]   cap_dat;
    logic [3:0]    cap_sel;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic [CW-1:0] tmo_cnt;

    logic tmo_hit;
    logic bus_term;
    logic term_err;

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A timeout is reported exactly like a slave error; err also beats ack.
    always_comb begin
        next_state = state;
        gnt_o      = 1'b0;
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        wb_we_o    = 1'b0;
        valid_o    = 1'b0;
        bus_term   = 1'b0;
        term_err   = 1'b0;
        case (state)
            IDLE: begin
                gnt_o = !rst_i;
                if (req_i) begin
                    next_state = BUS;
                end
            end
            BUS: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = cap_we;
                if (wb_err_i || (tmo_hit && !wb_ack_i)) begin
                    term_err = 1'b1;
                    bus_term = 1'b1;
                end else if (wb_ack_i) begin
                    bus_term = 1'b1;
                end
                if (bus_term) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                valid_o    = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, timeout counting and response latching.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_we    <= 1'b0;
            cap_adr   <= '0;
            cap_dat   <= '0;
            cap_sel   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            tmo_cnt   <= '0;
        end else if (state == IDLE && req_i) begin
            cap_we  <= we_i;
            cap_adr <= addr_i;
            cap_dat <= data_i;
            cap_sel <= sel_i;
            tmo_cnt <= '0;
        end else if (state == BUS) begin
            if (bus_term) begin
                resp_err  <= term_err;
                resp_data <= (term_err || cap_we) ? 32'd0 : wb_dat_i;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign wb_adr_o = cap_adr;
    assign wb_dat_o = cap_dat;
    assign wb_sel_o = cap_sel;
    assign data_o   = resp_data;
    assign err_o    = resp_err;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: read, write, error priority, timeout,
// back-to-back requests and reset abort, all checked against hand-derived values.
module tb_wb_master_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        gnt_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int testCount = 0;
    int failCount = 0;

    wb_master_bridge #(.TIMEOUT(16)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .sel_i    (sel_i),
        .gnt_o    (gnt_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .err_o    (err_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to the next cycle; inputs change and outputs are sampled 1-2 ns after the edge.
    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel);
        req_i  = req;
        we_i   = we;
        addr_i = adr;
        data_i = dat;
        sel_i  = sel;
    endtask

    task automatic slaveDrive(input logic ack, input logic err, input logic [31:0] dat);
        wb_ack_i = ack;
        wb_err_i = err;
        wb_dat_i = dat;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
        slaveDrive(1'b1, 1'b0, 32'hFFFF_FFFF);
        nextCycle();
        nextCycle();
        #1;
        // Reset state: everything low even with req and ack asserted.
        checkOutput("rst_gnt",   {31'd0, gnt_o},    32'd0);
        checkOutput("rst_cyc",   {31'd0, wb_cyc_o}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid_o},  32'd0);
        checkOutput("rst_adr",   wb_adr_o,          32'd0);
        checkOutput("rst_data",  data_o,            32'd0);
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        slaveDrive(1'b0, 1'b0, 32'd0);
        nextCycle();

        // Read, ack in cycle 2.
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        slaveDrive(1'b0, 1'b0, 32'd0);
        checkOutput("rd_c0_gnt", {31'd0, gnt_o}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveDrive(1'b0, 1'b0, 32'd0);
        checkOutput("rd_c1_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
        checkOutput("rd_c1_adr", wb_adr_o, 32'h100);
        checkOutput("rd_c1_we",  {31'd0, wb_we_o}, 32'd0);
        checkOutput("rd_c1_gnt", {31'd0, gnt_o}, 32'd0);
        nextCycle();
        slaveDrive(1'b1, 1'b0, 32'hDEADBEEF);
        checkOutput("rd_c2_adr", wb_adr_o, 32'h100);
        checkOutput("rd_c2_valid", {31'd0, valid_o}, 32'd0);
        nextCycle();
        slaveDrive(1'b0, 1'b0, 32'd0);
        checkOutput("rd_c3_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("rd_c3_data",  data_o, 32'hDEADBEEF);
        checkOutput("rd_c3_err",   {31'd0, err_o}, 32'd0);
        checkOutput("rd_c3_cyc",   {31'd0, wb_cyc_o}, 32'd0);
        nextCycle();
        checkOutput("rd_c4_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rd_c4_hold",  data_o, 32'hDEADBEEF);
        checkOutput("rd_c4_gnt",   {31'd0, gnt_o}, 32'd1);

        // Write, ack in cycle 1.
        applyStimulus(1'b1, 1'b1, 32'h4, 32'h12345678, 4'h3);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveDrive(1'b1, 1'b0, 32'hCAFEF00D);
        checkOutput("wr_c1_we",  {31'd0, wb_we_o}, 32'd1);
        checkOutput("wr_c1_dat", wb_dat_o, 32'h12345678);
        checkOutput("wr_c1_sel", {28'd0, wb_sel_o}, 32'h3);
        checkOutput("wr_c1_adr", wb_adr_o, 32'h4);
        nextCycle();
        slaveDrive(1'b0, 1'b0, 32'd0);
        checkOutput("wr_c2_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("wr_c2_data",  data_o, 32'd0);
        checkOutput("wr_c2_err",   {31'd0, err_o}, 32'd0);
        checkOutput("wr_c2_we",    {31'd0, wb_we_o}, 32'd0);
        nextCycle();
        checkOutput("wr_idle_adr_hold", wb_adr_o, 32'h4);
        checkOutput("wr_idle_dat_hold", wb_dat_o, 32'h12345678);

        // Error wins over a simultaneous ack.
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveDrive(1'b1, 1'b1, 32'h5555AAAA);
        nextCycle();
        slaveDrive(1'b0, 1'b0, 32'd0);
        checkOutput("errp_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("errp_err",   {31'd0, err_o}, 32'd1);
        checkOutput("errp_data",  data_o, 32'd0);
        nextCycle();

        // Timeout: slave silent, cyc must stay high for exactly 16 cycles.
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n = 0;
        while (wb_cyc_o === 1'b1 && n < 40) begin
            n++;
            nextCycle();
        end
        checkOutput("tmo_cycles", n, 32'd16);
        checkOutput("tmo_valid",  {31'd0, valid_o}, 32'd1);
        checkOutput("tmo_err",    {31'd0, err_o}, 32'd1);
        checkOutput("tmo_data",   data_o, 32'd0);
        nextCycle();

        // Back-to-back reads with req held high.
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        checkOutput("b2b_c0_gnt", {31'd0, gnt_o}, 32'd1);
        nextCycle();
        slaveDrive(1'b1, 1'b0, 32'h0000_00A1);
        checkOutput("b2b_c1_gnt", {31'd0, gnt_o}, 32'd0);
        nextCycle();
        slaveDrive(1'b0, 1'b0, 32'd0);
        checkOutput("b2b_c2_gnt",   {31'd0, gnt_o}, 32'd0);
        checkOutput("b2b_c2_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("b2b_c2_data",  data_o, 32'h0000_00A1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        checkOutput("b2b_c3_gnt", {31'd0, gnt_o}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveDrive(1'b1, 1'b0, 32'h0000_00B2);
        checkOutput("b2b_c4_gnt", {31'd0, gnt_o}, 32'd0);
        checkOutput("b2b_c4_adr", wb_adr_o, 32'h44);
        nextCycle();
        slaveDrive(1'b0, 1'b0, 32'd0);
        checkOutput("b2b_c5_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("b2b_c5_data",  data_o, 32'h0000_00B2);
        nextCycle();
        slaveDrive(1'b1, 1'b1, 32'h0000_00C3);
        checkOutput("stray_c6_valid", {31'd0, valid_o}, 32'd0);
        nextCycle();
        slaveDrive(1'b0, 1'b0, 32'd0);
        checkOutput("stray_c7_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("stray_c7_data",  data_o, 32'h0000_00B2);
        checkOutput("stray_c7_err",   {31'd0, err_o}, 32'd0);
        checkOutput("stray_c7_cyc",   {31'd0, wb_cyc_o}, 32'd0);
        nextCycle();

        // Reset in the middle of a read.
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("rstm_c1_cyc", {31'd0, wb_cyc_o}, 32'd1);
        nextCycle();
        rst_i = 1'b1;
        #1;
        checkOutput("rstm_c2_gnt",   {31'd0, gnt_o}, 32'd0);
        checkOutput("rstm_c2_valid", {31'd0, valid_o}, 32'd0);
        nextCycle();
        rst_i = 1'b0;
        #1;
        checkOutput("rstm_c3_cyc",   {31'd0, wb_cyc_o}, 32'd0);
        checkOutput("rstm_c3_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rstm_c3_gnt",   {31'd0, gnt_o}, 32'd1);
        checkOutput("rstm_c3_adr",   wb_adr_o, 32'd0);
        checkOutput("rstm_c3_data",  data_o, 32'd0);
        nextCycle();
        checkOutput("rstm_c4_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rstm_c4_cyc",   {31'd0, wb_cyc_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
